// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the RGB LED sequencer: FSM state encoding and field widths.
package led_ctrl_pkg;

  localparam int PWM_BITS_DEF      = 8;
  localparam int HOLD_BITS_DEF     = 16;
  localparam int STEP_LOG2_DEF     = 12;
  localparam int WARMUP_CYCLES_DEF = 1200;
  localparam int NUM_CH            = 3;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_FADE   = 2'd2,
    ST_HOLD   = 2'd3
  } led_state_t;

  // Width of a counter that must reach n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One colour channel: latched target, duty ramp of +/-1 per step, PWM compare register.
module led_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PWM_BITS-1:0] i_pc,
  input  logic                i_step,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [PWM_BITS-1:0] i_target,
  output logic                o_at_target,
  output logic                o_target_zero,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_target;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_pwm;
  logic                w_at_target;

  assign w_at_target = (r_duty == r_target);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_target <= '0;
      r_duty   <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_load) begin
        r_target <= i_target;
      end else if (i_clear) begin
        r_target <= '0;
      end
      // Stepping only while off-target keeps the duty from wrapping at either end.
      if (i_step && !w_at_target) begin
        r_duty <= (r_duty < r_target) ? r_duty + 1'b1 : r_duty - 1'b1;
      end
      r_pwm <= (i_pc < r_duty);
    end
  end

  assign o_at_target   = w_at_target;
  assign o_target_zero = (r_target == '0);
  assign o_pwm         = r_pwm;

endmodule

// File: rtl/rgb_led_sequencer.sv
// Drives SB_RGBA_DRV: powers up CURREN then RGBLEDEN, ramps three PWM channels to commanded
// colours, holds, fades out and powers down.
module rgb_led_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS      = PWM_BITS_DEF,
  parameter int STEP_LOG2     = STEP_LOG2_DEF,
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF,
  parameter int HOLD_BITS     = HOLD_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [PWM_BITS-1:0]  i_cmd_red,
  input  logic [PWM_BITS-1:0]  i_cmd_green,
  input  logic [PWM_BITS-1:0]  i_cmd_blue,
  input  logic [HOLD_BITS-1:0] i_cmd_hold,
  output logic                 o_busy,
  output logic                 o_curren,
  output logic                 o_rgbleden,
  output logic                 o_pwm_red,
  output logic                 o_pwm_green,
  output logic                 o_pwm_blue
);

  localparam int WARM_W = cnt_width(WARMUP_CYCLES);

  led_state_t           r_state;
  led_state_t           w_state_next;
  logic [STEP_LOG2-1:0] r_presc;
  logic [PWM_BITS-1:0]  r_pc;
  logic [WARM_W-1:0]    r_warm;
  logic [HOLD_BITS-1:0] r_hold;

  logic                 w_tick;
  logic                 w_accept;
  logic                 w_colour_zero;
  logic                 w_hold_expire;
  logic                 w_all_at_target;
  logic                 w_targets_zero;
  logic                 w_step;

  logic [PWM_BITS-1:0]  w_cmd_col [NUM_CH];
  logic [NUM_CH-1:0]    w_at_target;
  logic [NUM_CH-1:0]    w_target_zero;
  logic [NUM_CH-1:0]    w_pwm;

  assign w_cmd_col[0] = i_cmd_red;
  assign w_cmd_col[1] = i_cmd_green;
  assign w_cmd_col[2] = i_cmd_blue;

  assign w_tick          = &r_presc;
  assign w_accept        = i_cmd_valid & o_cmd_ready;
  assign w_colour_zero   = (i_cmd_red == '0) && (i_cmd_green == '0) && (i_cmd_blue == '0);
  assign w_all_at_target = &w_at_target;
  assign w_targets_zero  = &w_target_zero;
  assign w_step          = (r_state == ST_FADE) && w_tick;
  // A command arriving on the expiry tick takes priority; the expiry is dropped.
  assign w_hold_expire   = (r_state == ST_HOLD) && !w_accept && w_tick &&
                           (r_hold == HOLD_BITS'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      led_pwm_channel #(
        .PWM_BITS(PWM_BITS)
      ) u_ch (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pc         (r_pc),
        .i_step       (w_step),
        .i_load       (w_accept),
        .i_clear      (w_hold_expire),
        .i_target     (w_cmd_col[gi]),
        .o_at_target  (w_at_target[gi]),
        .o_target_zero(w_target_zero[gi]),
        .o_pwm        (w_pwm[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF:    if (w_accept && !w_colour_zero) w_state_next = ST_WARMUP;
      ST_WARMUP: if (r_warm == WARM_W'(WARMUP_CYCLES - 1)) w_state_next = ST_FADE;
      ST_FADE:   if (w_all_at_target) w_state_next = w_targets_zero ? ST_OFF : ST_HOLD;
      ST_HOLD:   if (w_accept || w_hold_expire) w_state_next = ST_FADE;
      default:   w_state_next = ST_OFF;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_curren    = 1'b1;
    o_rgbleden  = 1'b0;
    case (r_state)
      ST_OFF: begin
        o_cmd_ready = ~i_rst;
        o_busy      = 1'b0;
        o_curren    = 1'b0;
      end
      ST_WARMUP: ;
      ST_FADE:   o_rgbleden = 1'b1;
      ST_HOLD: begin
        o_cmd_ready = ~i_rst;
        o_rgbleden  = 1'b1;
      end
      default: begin
        o_busy   = 1'b0;
        o_curren = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_pc    <= '0;
      r_warm  <= '0;
      r_hold  <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_pc    <= r_pc + 1'b1;
      if (r_state == ST_OFF) begin
        r_warm <= '0;
      end else if (r_state == ST_WARMUP) begin
        r_warm <= r_warm + 1'b1;
      end
      // Zero hold means "until the next command", so it is never decremented.
      if (w_accept) begin
        r_hold <= i_cmd_hold;
      end else if ((r_state == ST_HOLD) && w_tick && (r_hold != '0)) begin
        r_hold <= r_hold - 1'b1;
      end
    end
  end

  assign o_pwm_red   = w_pwm[0];
  assign o_pwm_green = w_pwm[1];
  assign o_pwm_blue  = w_pwm[2];

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Scoreboard bench for rgb_led_sequencer: a behavioural model queues the expected outputs of
// every clock cycle; a negedge monitor pops and compares them against the DUT.
module tb_rgb_led_sequencer;

  localparam int PB   = 8;
  localparam int SL   = 2;
  localparam int WC   = 8;
  localparam int HB   = 16;
  localparam int STEP = 1 << SL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [PB-1:0] cr = '0;
  logic [PB-1:0] cg = '0;
  logic [PB-1:0] cb = '0;
  logic [HB-1:0] ch = '0;
  logic          o_cmd_ready, o_busy, o_curren, o_rgbleden;
  logic          o_pwm_red, o_pwm_green, o_pwm_blue;

  always #5 clk = ~clk;

  rgb_led_sequencer #(
    .PWM_BITS(PB), .STEP_LOG2(SL), .WARMUP_CYCLES(WC), .HOLD_BITS(HB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_red(cr), .i_cmd_green(cg), .i_cmd_blue(cb), .i_cmd_hold(ch),
    .o_busy(o_busy), .o_curren(o_curren), .o_rgbleden(o_rgbleden),
    .o_pwm_red(o_pwm_red), .o_pwm_green(o_pwm_green), .o_pwm_blue(o_pwm_blue)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_OFF, M_WARM, M_FADE, M_HOLD} mmode_t;
  mmode_t     m_mode = M_OFF;
  int         m_edges, m_warm, m_hold;
  int         m_duty [3];
  int         m_tgt  [3];
  bit         m_pwm  [3];
  logic [6:0] exp_q  [$];

  function automatic logic [6:0] model_out();
    logic rdy, on, led;
    rdy = (m_mode == M_OFF) || (m_mode == M_HOLD);
    on  = (m_mode != M_OFF);
    led = (m_mode == M_FADE) || (m_mode == M_HOLD);
    return {rdy, on, on, led, m_pwm[0], m_pwm[1], m_pwm[2]};
  endfunction

  function automatic void model_reset();
    m_mode = M_OFF; m_edges = 0; m_warm = 0; m_hold = 0;
    for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_tgt[c] = 0; m_pwm[c] = 0; end
  endfunction

  function automatic void model_step();
    bit tick, accept, all_at, tz;
    int pc;
    int cmd [3];
    tick   = (m_edges % STEP) == (STEP - 1);
    pc     = m_edges % 256;
    accept = (valid === 1'b1) && ((m_mode == M_OFF) || (m_mode == M_HOLD));
    cmd[0] = int'(cr); cmd[1] = int'(cg); cmd[2] = int'(cb);
    all_at = 1; tz = 1;
    for (int c = 0; c < 3; c++) begin
      m_pwm[c] = (pc < m_duty[c]);
      if (m_duty[c] != m_tgt[c]) all_at = 0;
      if (m_tgt[c] != 0) tz = 0;
    end
    case (m_mode)
      M_OFF: if (accept) begin
        m_tgt = cmd; m_hold = int'(ch);
        if (cmd[0] + cmd[1] + cmd[2] != 0) begin m_mode = M_WARM; m_warm = 0; end
      end
      M_WARM: begin
        m_warm++;
        if (m_warm == WC) m_mode = M_FADE;
      end
      M_FADE: begin
        if (all_at) m_mode = tz ? M_OFF : M_HOLD;
        else if (tick)
          for (int c = 0; c < 3; c++)
            if (m_duty[c] < m_tgt[c]) m_duty[c]++;
            else if (m_duty[c] > m_tgt[c]) m_duty[c]--;
      end
      M_HOLD: begin
        if (accept) begin
          m_tgt = cmd; m_hold = int'(ch); m_mode = M_FADE;
        end else if (tick && m_hold != 0) begin
          m_hold--;
          if (m_hold == 0) begin
            for (int c = 0; c < 3; c++) m_tgt[c] = 0;
            m_mode = M_FADE;
          end
        end
      end
      default: m_mode = M_OFF;
    endcase
    m_edges++;
    exp_q.push_back(model_out());
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // ---------------- monitor ----------------
  int mon_cyc = 0;
  always @(negedge clk) begin
    logic [6:0] e, a;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {o_cmd_ready, o_busy, o_curren, o_rgbleden, o_pwm_red, o_pwm_green, o_pwm_blue};
      mon_cyc++;
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL lockstep cyc=%0d: got rdy/busy/curr/led/rgb=%b, expected %b",
                    mon_cyc, a, e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(negedge clk); #1;
  endtask

  task automatic send_cmd(input int r, input int g, input int b, input int h,
                          output int waited);
    bit rdy;
    waited = 0;
    cr = PB'(r); cg = PB'(g); cb = PB'(b); ch = HB'(h);
    valid = 1'b1;
    forever begin
      rdy = o_cmd_ready;
      @(posedge clk);
      if (rdy) break;
      next_cycle();
      waited++;
      if (waited > 400) begin timeout_fail("send_cmd_ready"); break; end
    end
    next_cycle();
    valid = 1'b0;
    $display("cmd R=%0d G=%0d B=%0d hold=%0d accepted after %0d wait cycles", r, g, b, h, waited);
  endtask

  task automatic wait_mode(input mmode_t m, input int budget, input string name);
    int i;
    for (i = 0; i < budget && m_mode != m; i++) next_cycle();
    if (m_mode != m) timeout_fail(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, cnt, hi_r, hi_g, r, g, b;
    logic [6:0] outs;

    // reset state
    rst = 1'b1;
    repeat (3) next_cycle();
    outs = {o_cmd_ready, o_busy, o_curren, o_rgbleden, o_pwm_red, o_pwm_green, o_pwm_blue};
    check("reset_outputs", int'(outs), 0);
    rst = 1'b0;
    #1;
    check("release_ready", int'(o_cmd_ready), 1);
    check("release_busy", int'(o_busy), 0);
    next_cycle();

    // R=4 G=0 B=2 hold=3 from OFF: warmup, ramp, hold, fade-out, power-down
    send_cmd(4, 0, 2, 3, w);
    cnt = 0;
    for (int i = 0; i < 50 && !o_rgbleden; i++) begin
      if (o_curren) cnt++;
      next_cycle();
    end
    check("warmup_len", cnt, WC);
    wait_mode(M_HOLD, 200, "A_reach_hold");
    wait_mode(M_OFF, 200, "A_reach_off");
    next_cycle();
    check("A_off_busy", int'(o_busy), 0);
    check("A_off_curren", int'(o_curren), 0);

    // all-zero command in OFF: accepted, nothing powers up
    send_cmd(0, 0, 0, 5, w);
    check("B_zero_wait", w, 0);
    repeat (12) next_cycle();
    check("B_busy", int'(o_busy), 0);
    check("B_curren", int'(o_curren), 0);

    // full-scale red with infinite hold: 255 of 256 cycles high
    send_cmd(255, 0, 0, 0, w);
    wait_mode(M_HOLD, 1500, "C_reach_hold");
    repeat (2) next_cycle();
    hi_r = 0; hi_g = 0;
    for (int i = 0; i < 256; i++) begin
      hi_r += int'(o_pwm_red);
      hi_g += int'(o_pwm_green);
      next_cycle();
    end
    check("C_red_high_cycles", hi_r, 255);
    check("C_green_high_cycles", hi_g, 0);
    repeat (300) next_cycle();
    check("C_still_holding", int'(o_cmd_ready & o_rgbleden), 1);

    // retarget from HOLD: no warmup, duty walks down and returns to HOLD
    send_cmd(10, 0, 0, 0, w);
    check("D_accept_wait_10", w, 0);
    wait_mode(M_HOLD, 1500, "D_reach_hold_10");
    check("D_ready_in_hold", int'(o_cmd_ready), 1);
    send_cmd(3, 0, 0, 0, w);
    check("D_accept_wait_3", w, 0);
    wait_mode(M_HOLD, 200, "D_reach_hold_3");
    check("D_curren", int'(o_curren), 1);

    // command presented on the very tick where hold would expire
    send_cmd(6, 0, 0, 2, w);
    wait_mode(M_HOLD, 200, "E_reach_hold");
    for (int i = 0; i < 100 && !(m_mode == M_HOLD && m_hold == 1 && (m_edges % STEP) == STEP - 1);
         i++) next_cycle();
    send_cmd(9, 5, 0, 0, w);
    check("E_boundary_wait", w, 0);
    wait_mode(M_HOLD, 200, "E_new_hold");
    repeat (40) next_cycle();
    check("E_still_lit", int'(o_rgbleden), 1);

    // randomized command stream
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 4)) next_cycle();
      if ($urandom_range(0, 4) == 0) begin r = 0; g = 0; b = 0; end
      else begin
        r = $urandom_range(0, 12); g = $urandom_range(0, 12); b = $urandom_range(0, 12);
      end
      send_cmd(r, g, b, $urandom_range(0, 3), w);
    end
    send_cmd(0, 0, 0, 0, w);
    wait_mode(M_OFF, 400, "F_power_down");
    next_cycle();
    check("F_off_busy", int'(o_busy), 0);

    // asynchronous reset in the middle of a ramp
    send_cmd(12, 12, 12, 1, w);
    wait_mode(M_FADE, 100, "G_reach_fade");
    repeat (20) next_cycle();
    rst = 1'b1;
    #1;
    outs = {o_cmd_ready, o_busy, o_curren, o_rgbleden, o_pwm_red, o_pwm_green, o_pwm_blue};
    check("G_async_reset_outputs", int'(outs), 0);
    repeat (2) next_cycle();
    rst = 1'b0;
    #1;
    check("G_ready_after_reset", int'(o_cmd_ready), 1);
    repeat (4) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
